// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers N exponent values, sums them, then emits
// p[i] = floor(e[i]*2^DW / S) per element using a serial restoring divider.
module softmax_norm #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int SW = DW + $clog2(N);
  localparam int RW = SW + 1;
  localparam int QW = DW + 1;
  localparam int KW = $clog2(DW + 1);

  typedef enum logic [1:0] {LOAD, DIV, OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [KW-1:0]   step_q, step_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic [DW-1:0]   elem_mem [N];

  logic            in_fire;
  logic            out_fire;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   nxt_idx;
  logic            rem_ge;
  logic [RW-1:0]   rem_sub;
  logic [QW-1:0]   quo_next;
  logic            last_step;
  logic            last_elem;
  logic [DW-1:0]   result;

  assign in_fire   = (state_q == LOAD) && in_ready_q && in_valid;
  assign out_fire  = (state_q == OUT) && out_valid_q && out_ready;
  assign idx       = cnt_q[IW-1:0];
  assign nxt_idx   = idx + IW'(1);
  assign last_elem = (idx == IW'(N - 1));
  assign last_step = (step_q == KW'(DW));

  // One restoring step: the remainder never exceeds 2*S, so RW bits suffice.
  assign rem_ge   = (rem_q >= RW'(sum_q));
  assign rem_sub  = rem_ge ? (rem_q - RW'(sum_q)) : rem_q;
  assign quo_next = {quo_q[QW-2:0], rem_ge};

  // Quotient 2^DW only occurs when e == S; an all-zero vector forces 0.
  always_comb begin
    if (sum_q == '0) begin
      result = '0;
    end else if (quo_next[DW]) begin
      result = '1;
    end else begin
      result = quo_next[DW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    step_d      = step_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      LOAD: begin
        if (cnt_q == CW'(N)) begin
          state_d    = DIV;
          cnt_d      = '0;
          rem_d      = RW'(elem_mem[0]);
          quo_d      = '0;
          step_d     = '0;
          in_ready_d = 1'b0;
        end else begin
          if (in_fire) begin
            cnt_d = cnt_q + CW'(1);
            sum_d = sum_q + SW'(in_data);
          end
          in_ready_d = (cnt_d != CW'(N));
        end
      end
      DIV: begin
        rem_d  = rem_sub << 1;
        quo_d  = quo_next;
        step_d = step_q + KW'(1);
        if (last_step) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_data_d  = result;
          out_last_d  = last_elem;
        end
      end
      OUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (last_elem) begin
            state_d    = LOAD;
            cnt_d      = '0;
            sum_d      = '0;
            in_ready_d = 1'b1;
          end else begin
            state_d = DIV;
            cnt_d   = cnt_q + CW'(1);
            rem_d   = RW'(elem_mem[nxt_idx]);
            quo_d   = '0;
            step_d  = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      step_q      <= step_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Element buffer needs no reset: the counter decides which entries are live.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      elem_mem[idx] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm: fixed vectors with hand-derived
// probabilities, stall/reset scenarios, and a small random pass.
module tb_softmax_norm;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  int tests_run;
  int tests_failed;

  softmax_norm #(.N(4), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_p(input int e, input int s);
    int q;
    if (s == 0) return 0;
    q = (e * 256) / s;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic send_vec(input logic [7:0] e [4], input bit rnd);
    int i;
    int guard;
    bit x;
    i = 0;
    guard = 0;
    while (i < 4 && guard < 200) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = e[i];
      x = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (x) i++;
    end
    in_valid = 1'b0;
    check_val("load_done", i, 4);
    check_val("in_ready_drop", int'(in_ready), 0);
  endtask

  task automatic recv_one(input int exp_d, input int exp_l, input int exp_lat,
                          input int stall, input bit junk);
    int n;
    bit found;
    logic [7:0] held;
    n = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      @(posedge clk); #1;
      n++;
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      if (out_valid) found = 1'b1;
    end
    check_val("out_valid_seen", int'(found), 1);
    if (!found) return;
    check_val("latency", n, exp_lat);
    check_val("out_data", int'(out_data), exp_d);
    check_val("out_last", int'(out_last), exp_l);
    $display("[TB] out p=%0d last=%0d latency=%0d stall=%0d", out_data, out_last, n, stall);
    held = out_data;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_val("hold_valid", int'(out_valid), 1);
      check_val("hold_data", int'(out_data), int'(held));
      check_val("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("valid_drop", int'(out_valid), 0);
    if (exp_l != 0) check_val("in_ready_back", int'(in_ready), 1);
  endtask

  task automatic run_vec(input logic [7:0] e [4], input bit rnd, input bit junk,
                         input int stall_idx, input int stall_n);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(e[i]);
    $display("[TB] in  vector %0d,%0d,%0d,%0d S=%0d", e[0], e[1], e[2], e[3], s);
    send_vec(e, rnd);
    for (int i = 0; i < 4; i++) begin
      recv_one(ref_p(int'(e[i]), s), (i == 3) ? 1 : 0, (i == 0) ? 10 : 9,
               (i == stall_idx) ? stall_n : 0, junk);
    end
  endtask

  initial begin
    logic [7:0] v [4];
    tests_run    = 0;
    tests_failed = 0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_in_ready", int'(in_ready), 0);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_data", int'(out_data), 0);
    check_val("rst_out_last", int'(out_last), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("in_ready_pre_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    check_val("in_ready_after_rst", int'(in_ready), 1);

    // Uniform vector and hand-computed mixed vector.
    v = '{8'd16, 8'd16, 8'd16, 8'd16};
    run_vec(v, 1'b0, 1'b0, -1, 0);
    v = '{8'd6, 8'd10, 8'd16, 8'd32};
    send_vec(v, 1'b0);
    recv_one(24, 0, 10, 0, 1'b0);
    recv_one(40, 0, 9, 0, 1'b0);
    recv_one(64, 0, 9, 0, 1'b0);
    recv_one(128, 1, 9, 0, 1'b0);

    // Saturation and all-zero vectors.
    v = '{8'd41, 8'd0, 8'd0, 8'd0};
    send_vec(v, 1'b0);
    recv_one(255, 0, 10, 0, 1'b0);
    recv_one(0, 0, 9, 0, 1'b0);
    recv_one(0, 0, 9, 0, 1'b0);
    recv_one(0, 1, 9, 0, 1'b0);
    v = '{8'd0, 8'd0, 8'd0, 8'd0};
    send_vec(v, 1'b0);
    recv_one(0, 0, 10, 0, 1'b0);
    recv_one(0, 0, 9, 0, 1'b0);
    recv_one(0, 0, 9, 0, 1'b0);
    recv_one(0, 1, 9, 0, 1'b0);

    // Backpressure on p[1].
    v = '{8'd6, 8'd10, 8'd16, 8'd32};
    send_vec(v, 1'b0);
    recv_one(24, 0, 10, 0, 1'b0);
    recv_one(40, 0, 9, 5, 1'b0);
    recv_one(64, 0, 9, 0, 1'b0);
    recv_one(128, 1, 9, 0, 1'b0);

    // Reset while dividing p[2], then a clean vector.
    send_vec(v, 1'b0);
    recv_one(24, 0, 10, 0, 1'b0);
    recv_one(40, 0, 9, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", int'(out_valid), 0);
    check_val("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("midrst_held_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check_val("midrst_in_ready_back", int'(in_ready), 1);
    check_val("midrst_no_stale", int'(out_valid), 0);
    v = '{8'd16, 8'd16, 8'd16, 8'd16};
    run_vec(v, 1'b0, 1'b0, -1, 0);

    // Random back-to-back vectors with in_valid gaps and junk during output.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = (r == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      run_vec(v, 1'b1, 1'b1, -1, 0);
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL provide parameter N, default 4, number of exponent values per softmax vector (2..8).
REQ-002 SHALL provide parameter DW, default 8, width of exponent input (unsigned Q4.4) and of probability output (unsigned Q0.8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  DW  exponent value e[i] from exp LUT stage, unsigned.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-010 SHALL have port out_data  output  DW  probability p[i], unsigned Q0.8.
REQ-011 SHALL have port out_last  output  1  high with p[N-1] of a vector.

Function
REQ-012 SHALL transfer input only on a rising edge where in_valid and in_ready are both high; N transfers form one vector, in order e[0]..e[N-1].
REQ-013 SHALL buffer all N elements of a vector and accumulate sum S, width DW+ceil(log2 N) (10 bits at defaults), with no overflow.
REQ-014 SHALL use states LOAD, DIV, OUT: LOAD -> DIV on the edge after the Nth transfer; DIV -> OUT after exactly DW+1 cycles; OUT -> DIV (next element) or OUT -> LOAD (after element N-1) on an output transfer.
REQ-015 SHALL hold in_ready high only in LOAD, registered; in_ready SHALL be low during DIV and OUT (no overlap of vectors).
REQ-016 SHALL compute p[i] = floor(e[i]*2^DW / S) by restoring shift-subtract division, one quotient bit per cycle, DW+1 quotient bits.
REQ-017 SHALL saturate p[i] to 2^DW-1 (0xFF) when the quotient equals 2^DW (e[i] == S).
REQ-018 SHALL output p[i] = 0 for every element when S == 0, with unchanged latency.
REQ-019 SHALL assert out_valid from the 10th rising edge (DW+2 at defaults) after the edge accepting e[N-1] for p[0], and DW+1 edges after each earlier output transfer for subsequent elements.
REQ-020 SHALL hold out_data, out_last and out_valid stable while out_valid is high and out_ready is low.
REQ-021 SHALL transfer output on a rising edge with out_valid and out_ready both high; out_valid SHALL drop the following cycle.
REQ-022 SHALL ignore in_data and in_valid outside LOAD and ignore out_ready outside OUT.
REQ-023 SHALL return to LOAD with element counter 0 and S cleared after the transfer of p[N-1].

Reset
REQ-024 SHALL, while rst_n is low, force state LOAD, element counter 0, S 0, in_ready 0, out_valid 0, out_last 0, out_data 0, independent of clk.
REQ-025 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-026 SHALL discard any partially loaded or partially divided vector when rst_n asserts mid-operation; no stale output after reset.

Verification
REQ-027 SHALL pass: vector 16,16,16,16 (S=64) -> out_data 0x40,0x40,0x40,0x40, out_last on 4th only.
REQ-028 SHALL pass: vector 6,10,16,32 (S=64) -> 24,40,64,128; p[0] out_valid exactly 10 edges after last input transfer.
REQ-029 SHALL pass: vector 41,0,0,0 -> 0xFF,0x00,0x00,0x00 (saturation); vector 0,0,0,0 -> 0,0,0,0.
REQ-030 SHALL pass: out_ready held low 5 cycles at p[1] of vector 6,10,16,32 -> out_data 40 stable, in_ready 0, resumes with 64.
REQ-031 SHALL pass: rst_n pulsed low during DIV of p[2] -> out_valid 0 immediately, in_ready 1 one edge after release, next vector 16,16,16,16 -> 0x40 x4.
REQ-032 SHALL pass: in_valid toggled randomly during LOAD with back-to-back vectors -> outputs match floor(e*256/S) reference model, saturated at 255.
